// File: rtl/multibyte_alu_seq.sv
// multibyte_alu_seq: drives an external 8-bit combinational ALU one byte per
// clock (LSB first) to perform NBYTES-wide AND/OR/ADD/SUB/SLTU operations.
module multibyte_alu_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [8*NBYTES-1:0]   opa_i,
  input  logic [8*NBYTES-1:0]   opb_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [8*NBYTES-1:0]   result_o,
  output logic                  zero_flag_o,
  output logic                  carry_flag_o,
  output logic [7:0]            alu_a_o,
  output logic [7:0]            alu_b_o,
  output logic [2:0]            alu_cs_o,
  output logic                  alu_cin_o,
  input  logic [7:0]            alu_s_i,
  input  logic                  alu_zero_i,
  input  logic                  alu_cout_i
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLTU = 3'b100;

  localparam logic [2:0] CS_AND = 3'b000;
  localparam logic [2:0] CS_OR  = 3'b001;
  localparam logic [2:0] CS_ADC = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [2:0]        op_q, op_d;
  logic [W-1:0]      opa_q, opa_d;
  logic [W-1:0]      opb_q, opb_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      result_q, result_d;
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;
  logic              fin_carry;
  logic              arith;
  logic              inv_b;
  logic              unused_alu_zero;

  // ALU zero is not trusted; the wide zero flag is derived from the result.
  assign unused_alu_zero = alu_zero_i;

  // Operation class decodes of the latched op.
  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLTU);
  assign inv_b = (op_q == OP_SUB) || (op_q == OP_SLTU);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= OP_AND;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
    end
  end

  // Next-state, byte sequencing and ALU drive.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    carry_d   = carry_q;
    acc_d     = acc_q;
    result_d  = result_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    fin_carry = 1'b0;
    alu_a_o   = 8'h00;
    alu_b_o   = 8'h00;
    alu_cs_o  = CS_AND;
    alu_cin_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && (op_i <= OP_SLTU)) begin
          state_d = S_RUN;
          op_d    = op_i;
          opa_d   = opa_i;
          opb_d   = opb_i;
          idx_d   = '0;
          carry_d = 1'b0;
          acc_d   = '0;
        end
      end

      S_RUN: begin
        alu_a_o = opa_q[8*idx_q +: 8];
        alu_b_o = inv_b ? ~opb_q[8*idx_q +: 8] : opb_q[8*idx_q +: 8];
        case (op_q)
          OP_AND:  alu_cs_o = CS_AND;
          OP_OR:   alu_cs_o = CS_OR;
          default: alu_cs_o = CS_ADC;
        endcase
        // SUB/SLTU add the inverted operand plus one on the first byte.
        if (arith) begin
          alu_cin_o = (idx_q == '0) ? inv_b : carry_q;
        end
        acc_d[8*idx_q +: 8] = alu_s_i;
        // Logic ops leave a stale carry on the ALU, so it is ignored there.
        if (arith) begin
          carry_d = alu_cout_i;
        end
        fin_carry = arith & alu_cout_i;
        if (idx_q == IDXW'(NBYTES - 1)) begin
          state_d  = S_DONE;
          result_d = (op_q == OP_SLTU) ? {{(W-1){1'b0}}, ~fin_carry} : acc_d;
          zf_d     = (result_d == '0);
          cf_d     = fin_carry;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign result_o     = result_q;
  assign zero_flag_o  = zf_q;
  assign carry_flag_o = cf_q;

endmodule

// File: tb/tb_multibyte_alu_seq.sv
// Scoreboard testbench for multibyte_alu_seq with a behavioural 8-bit ALU.
module tb_multibyte_alu_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  opa, opb;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          zero_flag, carry_flag;
  logic [7:0]    alu_a, alu_b, alu_s;
  logic [2:0]    alu_cs;
  logic          alu_cin, alu_zero, alu_cout;

  typedef struct {
    logic [W-1:0] res;
    logic         cf;
    logic         zf;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  logic prev_done;
  logic [W-1:0] last_res;

  multibyte_alu_seq #(.NBYTES(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .op_i         (op),
    .opa_i        (opa),
    .opb_i        (opb),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result),
    .zero_flag_o  (zero_flag),
    .carry_flag_o (carry_flag),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_cs_o     (alu_cs),
    .alu_cin_o    (alu_cin),
    .alu_s_i      (alu_s),
    .alu_zero_i   (alu_zero),
    .alu_cout_i   (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU model; logic ops present a stale carry of 1.
  always_comb begin
    alu_s    = 8'h00;
    alu_cout = 1'b1;
    case (alu_cs)
      3'b000:  alu_s = alu_a & alu_b;
      3'b001:  alu_s = alu_a | alu_b;
      3'b110:  {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      default: alu_s = 8'h00;
    endcase
    alu_zero = (alu_s == 8'h00);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    e.res = '0;
    e.cf  = 1'b0;
    case (o)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.cf  = s[W];
      end
      3'b011: begin
        e.res = a - b;
        e.cf  = (a >= b);
      end
      default: begin
        e.res = (a < b) ? W'(1) : W'(0);
        e.cf  = (a >= b);
      end
    endcase
    e.zf = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("carry_flag", 64'(carry_flag), 64'(e.cf));
        check("zero_flag", 64'(zero_flag), 64'(e.zf));
      end
      if (prev_done) check("done_width", 64'(prev_done), 64'(0));
    end
    prev_done = done;
  end

  // Issue one operation, check done latency, optionally poke ignored starts.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject);
    exp_t e;
    int   got;
    e = model(o, a, b);
    sb.push_back(e);
    last_res = e.res;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int k = 1; k <= 3 * NB; k++) begin
      @(posedge clk);
      #1;
      if (inject && k == 1) begin
        start = 1'b1; op = 3'b001; opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = k;
        break;
      end
    end
    check("latency", 64'(got), 64'(NB));
    if (inject) begin
      start = 1'b1; op = 3'b011; opa = 32'h0000_0001; opb = 32'h0000_0002;
    end
    @(posedge clk);
    #1 start = 1'b0;
    if (inject) check("start_in_done_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    n_vec = 0; n_err = 0; prev_done = 1'b0; last_res = '0;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_zf", 64'(zero_flag), 64'(0));
    check("rst_cf", 64'(carry_flag), 64'(0));
    check("rst_alu", 64'({alu_a, alu_b, alu_cs, alu_cin}), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(3'b011, 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op(3'b011, 32'h0000_0005, 32'h0000_0007, 1'b0);
    run_op(3'b100, 32'h0000_0005, 32'h0000_0007, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    run_op(3'b000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0);
    run_op(3'b001, 32'h0000_0000, 32'h0000_0000, 1'b0);

    // Starts during RUN and DONE are ignored; then an illegal op in IDLE.
    run_op(3'b010, 32'h1111_1111, 32'h2222_2222, 1'b1);
    @(negedge clk);
    start = 1'b1; op = 3'b111; opa = 32'h5555_5555; opb = 32'h1;
    @(posedge clk);
    #1 start = 1'b0;
    check("illegal_busy", 64'(busy), 64'(0));
    check("illegal_result", 64'(result), 64'(last_res));
    repeat (NB + 2) @(posedge clk);
    #1 check("illegal_hold", 64'(result), 64'(last_res));

    // Reset in RUN cycle 2 abandons the operation.
    @(negedge clk);
    start = 1'b1; op = 3'b010; opa = 32'hAAAA_AAAA; opb = 32'h5555_5555;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_flags", 64'({zero_flag, carry_flag}), 64'(0));
    check("midrst_alu", 64'({alu_a, alu_b, alu_cs, alu_cin}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (NB + 2) @(posedge clk);
    #1 check("midrst_no_done", 64'(result), 64'(0));

    run_op(3'b010, 32'h0000_00FF, 32'h0000_0001, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_op(3'($urandom_range(0, 4)), 32'($urandom), 32'($urandom), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1 check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multibyte_alu_seq.md
# multibyte_alu_seq

Sequencer that sits directly in front of the 8-bit combinational ALU and consumes its outputs in the same cycle. It performs NBYTES-wide AND, OR, ADD, SUB and unsigned set-less-than by driving the ALU one byte per clock, least-significant byte first. Carry is chained through the ALU's add-with-carry operation. Per-byte results and flags are collected into a wide result word, and the block signals completion with a one-cycle done pulse.

## Interface
- NBYTES, 4, operand width in bytes (≥2); W = 8*NBYTES
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLTU; 101–111 illegal
- opa, opb  input  W  operands, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- result  output  W  final result, held until next accepted start
- zero_flag  output  1  result == 0
- carry_flag  output  1  final carry (ADD: carry out; SUB/SLTU: 1 = no borrow, i.e. opa ≥ opb); 0 for AND/OR
- alu_a, alu_b  output  8  ALU operand bytes
- alu_cs  output  3  ALU operation select
- alu_cin  output  1  ALU carry in
- alu_s  input  8  ALU byte result
- alu_zero  input  1  ALU zero (unused; zero is computed from result)
- alu_cout  input  1  ALU carry out

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start with a legal op.
  - Latch op, opa and opb; set byte index idx = 0.
  - Clear the internal carry and the result accumulator.
  - start with an illegal op, or start while busy, is ignored with no other effect.
- RUN: drive byte idx each cycle.
  - alu_a = opa[8*idx+:8].
  - alu_b = opb byte, bitwise inverted for SUB and SLTU.
  - alu_cs: 000 for AND, 001 for OR, 110 (add-with-carry) for ADD, SUB and SLTU.
  - alu_cin: for ADD, 0 at idx=0; for SUB/SLTU, 1 at idx=0; otherwise the registered carry. AND/OR drive 0.
- Per RUN cycle, register alu_s into the accumulator byte idx. For arithmetic ops, register carry = alu_cout.
- alu_cout is ignored for AND/OR, because the ALU holds a stale carry_out for logic ops.
- The ALU's own subtract encodings (011, 101) are never used.
- When idx == NBYTES-1, go RUN → DONE; otherwise idx increments.
- On the RUN → DONE edge, load the outputs:
  - result = accumulator. For SLTU, result = {W-1 zeros, ~final carry}.
  - carry_flag = final carry; 0 for AND/OR.
  - zero_flag = (result == 0), computed from the loaded value.
- DONE: done = 1 for exactly one cycle, then → IDLE. A start present in DONE is ignored.
- Outside RUN: alu_a = alu_b = 0, alu_cs = 000, alu_cin = 0.
- Arithmetic is modulo 2^W; no signed interpretation.

## Timing
- Reset (async assert, any state) gives:
  - state IDLE, idx 0, internal carry 0.
  - busy 0, done 0, result 0, zero_flag 0, carry_flag 0.
  - ALU drive at the idle values above.
- Reset mid-RUN abandons the operation: no done pulse, result stays 0.
- Latency: start accepted at edge 0 → RUN covers cycles 1..NBYTES → done high in cycle NBYTES+1 (cycle 5 for NBYTES = 4).
- The next start is accepted no earlier than cycle NBYTES+2.
- result and flags change only on the RUN → DONE edge and are stable whenever done = 1.
- ALU path is combinational within the cycle: alu_* outputs are registered-state decodes, and alu_s/alu_cout are sampled at the end of the same cycle.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry_flag 1, zero_flag 1; done exactly in cycle 5; carry chains through all 4 bytes.
- SUB 0x12345678 − 0x12345678 → result 0, carry_flag 1, zero_flag 1. Checks that equal bytes propagate no borrow.
- SUB 0x00000005 − 0x00000007 → result 0xFFFFFFFE, carry_flag 0, zero_flag 0. Then SLTU on the same operands → result 0x00000001, carry_flag 0.
- AND 0xF0F0FF00 & 0x0FF0F0F0 → 0x00F0F000, carry_flag 0 (run immediately after an ADD that produced carry 1). OR 0 | 0 → result 0, zero_flag 1.
- Pulse start with a new op during RUN and in DONE, and start with op 111 in IDLE → each is ignored; the in-flight result is unchanged; no extra done pulse.
- Assert rst_n low during RUN cycle 2 → all outputs zero immediately; no done pulse. After release, ADD 0x000000FF + 0x00000001 → 0x00000100, carry_flag 0.
